pair_cmp_stage: RTL and testbench
=================================

PAIR_CMP_STAGE -- requirements
Module: pair_cmp_stage

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, setting the operand width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 8, setting the update-counter width in bits.
REQ-003 Port clk SHALL be a 1-bit input: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be a 1-bit input: reset, synchronous and active-high.
REQ-005 Port in_valid SHALL be a 1-bit input: upstream offers an operand pair.
REQ-006 Port in_ready SHALL be a 1-bit output: stage can accept a pair this cycle.
REQ-007 Port in_a SHALL be a WIDTH-bit input: operand a, unsigned.
REQ-008 Port in_b SHALL be a WIDTH-bit input: operand b, unsigned.
REQ-009 Port out_valid SHALL be a 1-bit output: result presented downstream.
REQ-010 Port out_ready SHALL be a 1-bit input: downstream takes the result this cycle.
REQ-011 Port out_c SHALL be a WIDTH-bit output: result value c.
REQ-012 Port out_d SHALL be a WIDTH-bit output: result value d.
REQ-013 Port out_upd SHALL be a 1-bit output: current result came from a pair with a > b.
REQ-014 Port upd_cnt SHALL be a CNT_W-bit output: number of updating results loaded since reset.
REQ-015 Port busy SHALL be a 1-bit output: FIFO occupancy nonzero or out_valid high.

Function
REQ-016 The stage SHALL hold accepted pairs in a 2-entry FIFO, occupancy 0..2, in acceptance order.
REQ-017 in_ready SHALL be 1 exactly when occupancy < 2, independent of any same-cycle pop (no bypass when full).
REQ-018 A pair SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_a/in_b are written to the FIFO tail on that edge.
REQ-019 The output slot SHALL be free when out_valid is 0 or out_ready is 1.
REQ-020 On an edge where occupancy > 0 and the output slot is free, the FIFO head SHALL be popped and the output register loaded; out_valid is 1 after that edge.
REQ-021 On an edge where the output slot is free and occupancy is 0, out_valid SHALL become 0; out_c/out_d/out_upd keep their values.
REQ-022 While out_valid is 1 and out_ready is 0, out_valid, out_c, out_d and out_upd SHALL hold stable.
REQ-023 Load with head a > b (unsigned): out_c SHALL take a, out_d SHALL take b, out_upd SHALL be 1, and upd_cnt SHALL increment by 1.
REQ-024 Load with head a <= b: out_c and out_d SHALL retain their previous values, out_upd SHALL be 0, and upd_cnt SHALL be unchanged.
REQ-025 upd_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Latency SHALL be 2 edges: a pair accepted at edge N appears at the output after edge N+1 if the output slot is free at N+1; otherwise it appears later.
REQ-027 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, and the new entry becomes head.
REQ-028 No accepted pair SHALL be dropped or duplicated; each is presented exactly once, in order.

Reset
REQ-029 While rst is 1 at a rising edge, the stage SHALL clear occupancy to 0, and set out_valid=0, out_c=0, out_d=0, out_upd=0 and upd_cnt=0.
REQ-030 in_ready SHALL be 1 and busy 0 in the cycle after a reset edge.
REQ-031 Reset SHALL override any same-edge accept, pop or load, including reset mid-stream; FIFO contents are discarded.

Verification
REQ-032 Bench SHALL run reset then one pair: pair a=5,b=3 at edge N, out_ready=1 -> after edge N+1 out_valid=1, c=5, d=3, upd=1, upd_cnt=1.
REQ-033 Bench SHALL cover hold: after a=5,b=3, send a=2,b=9 -> out_valid=1, c=5, d=3, upd=0, upd_cnt unchanged; then a=7,b=7 -> c=5, d=3, upd=0.
REQ-034 Bench SHALL cover backpressure: out_ready=0 with in_valid held at 1 -> three pairs taken (two in FIFO, one at output), then in_ready=0; release out_ready -> the three pairs emerge in order, none lost.
REQ-035 Bench SHALL cover saturation: CNT_W=2 with 5 updating pairs -> upd_cnt reads 1, 2, 3, 3, 3.
REQ-036 Bench SHALL cover reset mid-stream: rst=1 with FIFO full and out_valid=1 -> after the edge out_valid=0, c=d=0, upd_cnt=0, in_ready=1, busy=0.

Source files
------------

// File: rtl/pair_cmp_stage.sv
// pair_cmp_stage: a 2-entry FIFO feeding one output register that latches (a,b)
// only when a > b and counts those updates with saturation.  Revision: 1.0
`default_nettype none

module pair_cmp_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             out_upd,
  output logic [CNT_W-1:0] upd_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       DEPTH   = 2'd2;

  logic [WIDTH-1:0] mem_a [2];
  logic [WIDTH-1:0] mem_b [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic push;
  logic pop;
  logic slot_free;
  logic head_gt;

  // in_ready depends only on occupancy, never on a same-cycle pop.
  assign in_ready  = (count != DEPTH);
  assign slot_free = !out_valid || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = (count != 2'd0) && slot_free;
  assign head_gt   = mem_a[rd_ptr] > mem_b[rd_ptr];
  assign busy      = (count != 2'd0) || out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_d     <= '0;
      out_upd   <= 1'b0;
      upd_cnt   <= '0;
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= in_a;
        mem_b[wr_ptr] <= in_b;
        wr_ptr        <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        out_valid <= 1'b1;
        // Non-updating pairs still produce a result, but c/d keep the last winner.
        if (head_gt) begin
          out_c   <= mem_a[rd_ptr];
          out_d   <= mem_b[rd_ptr];
          out_upd <= 1'b1;
          if (upd_cnt != CNT_MAX) begin
            upd_cnt <= upd_cnt + 1'b1;
          end
        end else begin
          out_upd <= 1'b0;
        end
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pair_cmp_stage.sv
// Directed self-checking bench for pair_cmp_stage (WIDTH=8, CNT_W=2).
`default_nettype none

module tb_pair_cmp_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_c;
  logic [7:0] out_d;
  logic       out_upd;
  logic [1:0] upd_cnt;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  pair_cmp_stage #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_d(out_d), .out_upd(out_upd), .upd_cnt(upd_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    vectors++; if (out_c !== 8'd0) begin errors++; $display("FAIL rst_out_c got %0d exp 0", out_c); end
    vectors++; if (out_d !== 8'd0) begin errors++; $display("FAIL rst_out_d got %0d exp 0", out_d); end
    vectors++; if (out_upd !== 1'b0) begin errors++; $display("FAIL rst_out_upd got %0b exp 0", out_upd); end
    vectors++; if (upd_cnt !== 2'd0) begin errors++; $display("FAIL rst_upd_cnt got %0d exp 0", upd_cnt); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b exp 0", out_valid); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy); end
    tick();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", out_valid); end
    vectors++; if (out_c !== 8'd5 || out_d !== 8'd3) begin errors++; $display("FAIL single_cd got c=%0d d=%0d exp c=5 d=3", out_c, out_d); end
    vectors++; if (out_upd !== 1'b1) begin errors++; $display("FAIL single_upd got %0b exp 1", out_upd); end
    vectors++; if (upd_cnt !== 2'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", upd_cnt); end
    tick();
    vectors++; if (out_valid !== 1'b0 || out_c !== 8'd5) begin errors++; $display("FAIL single_drain got v=%0b c=%0d exp v=0 c=5", out_valid, out_c); end
  endtask

  task automatic test_hold();
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    pa[0] = 8'd2; pb[0] = 8'd9;
    pa[1] = 8'd7; pb[1] = 8'd7;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
      tick();
      in_valid = 1'b0;
      tick();
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %0b exp 1", i, out_valid); end
      vectors++; if (out_c !== 8'd5 || out_d !== 8'd3) begin errors++; $display("FAIL hold_cd[%0d] got c=%0d d=%0d exp c=5 d=3", i, out_c, out_d); end
      vectors++; if (out_upd !== 1'b0) begin errors++; $display("FAIL hold_upd[%0d] got %0b exp 0", i, out_upd); end
      vectors++; if (upd_cnt !== 2'd1) begin errors++; $display("FAIL hold_cnt[%0d] got %0d exp 1", i, upd_cnt); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    pa[0] = 8'd9; pb[0] = 8'd1;
    pa[1] = 8'd8; pb[1] = 8'd2;
    pa[2] = 8'd6; pb[2] = 8'd4;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_ready[%0d] got %0b exp 1", i, in_ready); end
      in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
      tick();
    end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", in_ready); end
    vectors++; if (out_valid !== 1'b1 || out_c !== 8'd9) begin errors++; $display("FAIL bp_head got v=%0b c=%0d exp v=1 c=9", out_valid, out_c); end
    // Offer a fourth pair that must be refused while full.
    in_a = 8'd3; in_b = 8'd0;
    tick();
    vectors++; if (in_ready !== 1'b0 || out_c !== 8'd9 || out_d !== 8'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall got rdy=%0b v=%0b c=%0d d=%0d exp rdy=0 v=1 c=9 d=1", in_ready, out_valid, out_c, out_d); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      vectors++; if (out_valid !== 1'b1 || out_c !== pa[i] || out_d !== pb[i]) begin
        errors++; $display("FAIL bp_drain[%0d] got v=%0b c=%0d d=%0d exp v=1 c=%0d d=%0d", i, out_valid, out_c, out_d, pa[i], pb[i]); end
    end
    tick();
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%0b busy=%0b exp v=0 busy=0", out_valid, busy); end
    vectors++; if (upd_cnt !== 2'd3) begin errors++; $display("FAIL bp_cnt got %0d exp 3", upd_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    apply_reset();
    out_ready = 1'b1;
    // Streamed back-to-back: push and pop coincide at occupancy 1.
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        in_valid = 1'b1; in_a = 8'(8'd200 + i); in_b = 8'(i);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
        vectors++; if (upd_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, upd_cnt, exp_cnt); end
        vectors++; if (out_valid !== 1'b1 || out_c !== 8'(8'd200 + i - 1)) begin
          errors++; $display("FAIL sat_out[%0d] got v=%0b c=%0d exp v=1 c=%0d", i, out_valid, out_c, 200 + i - 1); end
      end
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'(8'd50 + i); in_b = 8'd1;
      tick();
    end
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got rdy=%0b v=%0b exp rdy=0 v=1", in_ready, out_valid); end
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", out_valid); end
    vectors++; if (out_c !== 8'd0 || out_d !== 8'd0) begin errors++; $display("FAIL mid_cd got c=%0d d=%0d exp 0 0", out_c, out_d); end
    vectors++; if (upd_cnt !== 2'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", upd_cnt); end
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_ready_busy got rdy=%0b busy=%0b exp 1 0", in_ready, busy); end
    tick();
    tick();
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_discard got v=%0b busy=%0b exp 0 0", out_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
